hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Parametrised successor to the pipeline's combinational EX-stage forwarding logic.
- Generates forward selects for NUM_SRC source operands with EX/MEM-over-MEM/WB priority.
- Detects load-use hazards.
- Tracks one in-flight multi-cycle operation (mul/div) with a busy counter and a single-entry scoreboard, and stalls decode on RAW or structural conflicts.
- Sits between the ID/EX, EX/MEM and MEM/WB pipeline registers and the PC/IF-ID write enables. Also keeps a saturating stall-cycle counter for performance reads.

Parameters:
- AW, 5, register address width.
- NUM_SRC, 2, source operands per instruction.
- MC_LATENCY, 4, cycles a multi-cycle op occupies the unit (≥1).
- CW, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_src_addr  in  NUM_SRC*AW  decode-stage source register addresses, slot i at [i*AW +: AW].
- id_src_valid  in  NUM_SRC  decode source actually read.
- id_mc_start  in  1  decode instruction is a multi-cycle op.
- id_mc_rd  in  AW  its destination.
- id_flush  in  1  squash decode instruction (branch redirect).
- ex_src_addr  in  NUM_SRC*AW  ID/EX source addresses.
- idex_mem_read  in  1  EX instruction is a load.
- idex_reg_write  in  1  EX instruction writes a register.
- idex_rd  in  AW  EX destination.
- exmem_reg_write  in  1  EX/MEM writes a register.
- exmem_rd  in  AW  EX/MEM destination.
- memwb_reg_write  in  1  MEM/WB writes a register.
- memwb_rd  in  AW  MEM/WB destination.
- fwd_sel  out  NUM_SRC*2  per slot: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
- mc_busy  out  1  multi-cycle unit occupied.
- mc_done  out  1  one-cycle pulse in the final busy cycle.
- mc_rd_pending  out  AW  scoreboarded destination (0 when none).
- stall_count  out  CW  saturating count of stalled cycles.

Behaviour:
- Reset (async): state=IDLE, count=0, pend_valid=0, pend_rd=0, stall_count=0. Outputs then: mc_busy=0, mc_done=0, mc_rd_pending=0. fwd_sel and stall are combinational and follow inputs.
- Forwarding is combinational, per slot i:
  - 10 if exmem_reg_write & exmem_rd≠0 & exmem_rd==ex_src[i].
  - else 01 if memwb_reg_write & memwb_rd≠0 & memwb_rd==ex_src[i].
  - else 00.
  - EX/MEM always wins when both match.
- Load-use hazard: idex_mem_read & idex_reg_write & idex_rd≠0 & any slot with id_src_valid[i] & id_src[i]==idex_rd.
- Multi-cycle RAW hazard: pend_valid & any valid id_src[i]==pend_rd.
- Multi-cycle WAW hazard: pend_valid & id_mc_start & id_mc_rd==pend_rd.
- Structural hazard: id_mc_start & state==MC_RUN, including the mc_done cycle.
- stall = (load_use | mc_raw | mc_waw | structural) & ~id_flush. A flushed decode instruction never stalls.
- Accept: id_mc_start & ~stall & ~id_flush & state==IDLE.
- FSM, IDLE → MC_RUN on accept:
  - count ← MC_LATENCY-1.
  - pend_rd ← id_mc_rd.
  - pend_valid ← (id_mc_rd≠0).
- In MC_RUN:
  - count≠0: count decrements.
  - count==0: mc_done=1 that cycle; next edge → IDLE, pend_valid←0, pend_rd←0.
- Timing: start accepted at edge T → mc_busy high for cycles T..T+MC_LATENCY-1, mc_done in cycle T+MC_LATENCY-1. A new start is accepted at earliest in cycle T+MC_LATENCY.
- RAW stall on pend_rd persists through the mc_done cycle and releases the following cycle.
- mc_busy = (state==MC_RUN). mc_rd_pending = pend_valid ? pend_rd : 0.
- id_flush does not cancel an already-running op.
- stall_count increments each cycle stall=1 and holds at 2^CW-1.
- Reset mid-operation aborts the op immediately, with no mc_done pulse.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_e enumeration: FWD_RF=00, FWD_MEMWB=01, FWD_EXMEM=10.
  - state enumeration: IDLE, MC_RUN.
  - Default AW constant.
- Sub-module fwd_select: single-slot combinational forward priority mux, instantiated NUM_SRC times via generate.

Test Plan:
- exmem_rd=3 and memwb_rd=3, both writing, ex_src[0]=3 → fwd_sel[1:0]=10. Drop exmem_reg_write → 01. Set rd=0 → 00.
- idex load to rd=5, id_src[1]=5 valid → stall=1 one cycle, stall_count 0→1. Same with id_src_valid[1]=0 → stall=0.
- MC_LATENCY=4: start with rd=7 at edge T → mc_busy cycles T..T+3, mc_done at T+3. Decode reading r7 stalls through T+3 and proceeds at T+4.
- Second id_mc_start while busy → stall until T+4, accepted at T+4.
- id_flush=1 with a load-use match → stall=0, no start accepted.
- Assert reset at T+1 of a running op → mc_busy=0, mc_rd_pending=0 immediately; no mc_done; stall_count=0. Force stall for 2^CW+5 cycles with CW=4 → stall_count saturates at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard / forwarding unit.
//   fwd_sel_e : per-operand forward source encoding (regfile, MEM/WB, EX/MEM)
//   state_e   : multi-cycle tracker state
//   DEFAULT_AW: default register address width
package hazard_pkg;

    localparam int DEFAULT_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE   = 1'b0,
        MC_RUN = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Single-operand forward priority mux.
//   src_addr        : EX-stage source register address
//   exmem_reg_write : EX/MEM writes a register,  exmem_rd : its destination
//   memwb_reg_write : MEM/WB writes a register,  memwb_rd : its destination
//   sel             : forward select (EX/MEM has priority, r0 never forwards)
module fwd_select
    import hazard_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic [AW-1:0] src_addr,
    input  logic          exmem_reg_write,
    input  logic [AW-1:0] exmem_rd,
    input  logic          memwb_reg_write,
    input  logic [AW-1:0] memwb_rd,
    output fwd_sel_e      sel
);

    always_comb begin
        sel = FWD_RF;
        // The younger result (EX/MEM) is the architecturally newest value.
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src_addr)) begin
            sel = FWD_EXMEM;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src_addr)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage forwarding, load-use detection and multi-cycle (mul/div) tracking.
//   clk, reset       : clock, asynchronous active-high reset
//   id_*             : decode-stage sources, multi-cycle start/destination, flush
//   ex_src_addr      : ID/EX source addresses used for forwarding
//   idex_* / exmem_* / memwb_* : destination info of downstream pipeline regs
//   fwd_sel          : 2 bits per source slot (00 RF, 10 EX/MEM, 01 MEM/WB)
//   stall            : hold PC and IF/ID, bubble ID/EX
//   mc_busy, mc_done : multi-cycle unit occupied / final busy cycle pulse
//   mc_rd_pending    : scoreboarded destination, 0 when none
//   stall_count      : saturating count of stalled cycles
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int AW         = DEFAULT_AW,
    parameter int NUM_SRC    = 2,
    parameter int MC_LATENCY = 4,
    parameter int CW         = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SRC*AW-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]    id_src_valid,
    input  logic                  id_mc_start,
    input  logic [AW-1:0]         id_mc_rd,
    input  logic                  id_flush,
    input  logic [NUM_SRC*AW-1:0] ex_src_addr,
    input  logic                  idex_mem_read,
    input  logic                  idex_reg_write,
    input  logic [AW-1:0]         idex_rd,
    input  logic                  exmem_reg_write,
    input  logic [AW-1:0]         exmem_rd,
    input  logic                  memwb_reg_write,
    input  logic [AW-1:0]         memwb_rd,
    output logic [NUM_SRC*2-1:0]  fwd_sel,
    output logic                  stall,
    output logic                  mc_busy,
    output logic                  mc_done,
    output logic [AW-1:0]         mc_rd_pending,
    output logic [CW-1:0]         stall_count
);

    // A latency of 1 still needs a one-bit counter that simply holds 0.
    localparam int CNT_W = (MC_LATENCY > 1) ? $clog2(MC_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LATENCY - 1);

    state_e           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             pend_valid_reg;
    logic [AW-1:0]    pend_rd_reg;
    logic [CW-1:0]    stall_count_reg;

    logic [NUM_SRC-1:0] load_use_slot;
    logic [NUM_SRC-1:0] mc_raw_slot;
    logic load_use;
    logic mc_raw;
    logic mc_waw;
    logic structural;
    logic accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_slot
            logic [AW-1:0] ex_src;
            logic [AW-1:0] id_src;
            fwd_sel_e      slot_sel;

            assign ex_src = ex_src_addr[gi*AW +: AW];
            assign id_src = id_src_addr[gi*AW +: AW];

            fwd_select #(
                .AW(AW)
            ) u_fwd_select (
                .src_addr        (ex_src),
                .exmem_reg_write (exmem_reg_write),
                .exmem_rd        (exmem_rd),
                .memwb_reg_write (memwb_reg_write),
                .memwb_rd        (memwb_rd),
                .sel             (slot_sel)
            );

            assign fwd_sel[gi*2 +: 2]  = slot_sel;
            assign load_use_slot[gi]   = id_src_valid[gi] && (id_src == idex_rd);
            assign mc_raw_slot[gi]     = id_src_valid[gi] && (id_src == pend_rd_reg);
        end
    endgenerate

    assign load_use   = idex_mem_read && idex_reg_write && (idex_rd != '0) && (|load_use_slot);
    assign mc_raw     = pend_valid_reg && (|mc_raw_slot);
    assign mc_waw     = pend_valid_reg && id_mc_start && (id_mc_rd == pend_rd_reg);
    // Busy through the mc_done cycle: the unit frees only on the following edge.
    assign structural = id_mc_start && (state_reg == MC_RUN);

    // A squashed decode instruction must never hold the front end.
    assign stall  = (load_use || mc_raw || mc_waw || structural) && !id_flush;
    assign accept = id_mc_start && !stall && !id_flush && (state_reg == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            pend_valid_reg <= 1'b0;
            pend_rd_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg      <= MC_RUN;
                        count_reg      <= CNT_INIT;
                        pend_rd_reg    <= id_mc_rd;
                        // Writes to r0 are discarded, so they never block readers.
                        pend_valid_reg <= (id_mc_rd != '0);
                    end
                end
                MC_RUN: begin
                    if (count_reg != '0) begin
                        count_reg <= count_reg - CNT_W'(1);
                    end else begin
                        state_reg      <= IDLE;
                        pend_valid_reg <= 1'b0;
                        pend_rd_reg    <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_reg <= '0;
        end else if (stall && (stall_count_reg != '1)) begin
            stall_count_reg <= stall_count_reg + CW'(1);
        end
    end

    assign mc_busy       = (state_reg == MC_RUN);
    assign mc_done       = (state_reg == MC_RUN) && (count_reg == '0);
    assign mc_rd_pending = pend_valid_reg ? pend_rd_reg : '0;
    assign stall_count   = stall_count_reg;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scenario bench for hazard_forward_unit (AW=5, NUM_SRC=2, MC_LATENCY=4, CW=4).
// Each task drives one scenario, pushes the expected observation into the
// scoreboard when it drives stimulus, and pops/compares at the falling edge.
module tb_hazard_forward_unit;

    localparam int AW  = 5;
    localparam int NS  = 2;
    localparam int LAT = 4;
    localparam int CW  = 4;

    // Observation word: {fwd_sel[3:0], stall, mc_busy, mc_done, mc_rd_pending[4:0], stall_count[3:0]}
    localparam logic [15:0] M_FWD = 16'hF000;
    localparam logic [15:0] M_CTL = 16'h0FFF;
    localparam logic [15:0] M_ALL = 16'hFFFF;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NS*AW-1:0] id_src_addr = '0;
    logic [NS-1:0]    id_src_valid = '0;
    logic             id_mc_start = 1'b0;
    logic [AW-1:0]    id_mc_rd = '0;
    logic             id_flush = 1'b0;
    logic [NS*AW-1:0] ex_src_addr = '0;
    logic             idex_mem_read = 1'b0;
    logic             idex_reg_write = 1'b0;
    logic [AW-1:0]    idex_rd = '0;
    logic             exmem_reg_write = 1'b0;
    logic [AW-1:0]    exmem_rd = '0;
    logic             memwb_reg_write = 1'b0;
    logic [AW-1:0]    memwb_rd = '0;
    logic [NS*2-1:0]  fwd_sel;
    logic             stall;
    logic             mc_busy;
    logic             mc_done;
    logic [AW-1:0]    mc_rd_pending;
    logic [CW-1:0]    stall_count;
    logic [15:0]      obs;

    typedef struct {
        string       name;
        logic [15:0] exp;
        logic [15:0] mask;
    } sb_t;

    sb_t         sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [3:0]  exp_cnt = '0;

    always #5 clk = ~clk;

    assign obs = {fwd_sel, stall, mc_busy, mc_done, mc_rd_pending, stall_count};

    hazard_forward_unit #(
        .AW(AW), .NUM_SRC(NS), .MC_LATENCY(LAT), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
        .id_mc_start(id_mc_start), .id_mc_rd(id_mc_rd), .id_flush(id_flush),
        .ex_src_addr(ex_src_addr),
        .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write), .idex_rd(idex_rd),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .fwd_sel(fwd_sel), .stall(stall), .mc_busy(mc_busy), .mc_done(mc_done),
        .mc_rd_pending(mc_rd_pending), .stall_count(stall_count)
    );

    function automatic logic [15:0] ev(input logic [3:0] f, input logic s, input logic b,
                                       input logic d, input logic [4:0] p, input logic [3:0] c);
        return {f, s, b, d, p, c};
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : v + 4'd1;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_src_addr = '0; id_src_valid = '0; id_mc_start = 1'b0; id_mc_rd = '0;
        id_flush = 1'b0; ex_src_addr = '0; idex_mem_read = 1'b0; idex_reg_write = 1'b0;
        idex_rd = '0; exmem_reg_write = 1'b0; exmem_rd = '0; memwb_reg_write = 1'b0;
        memwb_rd = '0;
    endtask

    task automatic test_reset();
        sb_t ent;
        clear_inputs();
        reset = 1'b1;
        sb.push_back('{"reset_state", ev(4'b0000, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0), M_ALL});
        @(negedge clk);
        ent = sb.pop_front();
        checks++;
        if ((obs & ent.mask) !== (ent.exp & ent.mask)) begin
            errors++;
            $display("FAIL %s: got %h required %h", ent.name, obs & ent.mask, ent.exp & ent.mask);
        end else $display("txn %s obs=%h", ent.name, obs);
        next_cycle();
        reset = 1'b0;
        exp_cnt = '0;
        next_cycle();
    endtask

    task automatic test_forwarding();
        sb_t ent;
        // {ex_src1, ex_src0, exmem_we, exmem_rd, memwb_we, memwb_rd, expected fwd_sel}
        logic [4:0] s1 [4] = '{5'd9, 5'd9, 5'd9, 5'd4};
        logic [4:0] s0 [4] = '{5'd3, 5'd3, 5'd3, 5'd3};
        logic       ew [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [4:0] er [4] = '{5'd3, 5'd3, 5'd0, 5'd3};
        logic       mw [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic [4:0] mr [4] = '{5'd3, 5'd3, 5'd0, 5'd4};
        logic [3:0] fe [4] = '{4'b0010, 4'b0001, 4'b0000, 4'b0110};
        for (int k = 0; k < 4; k++) begin
            ex_src_addr = {s1[k], s0[k]};
            exmem_reg_write = ew[k]; exmem_rd = er[k];
            memwb_reg_write = mw[k]; memwb_rd = mr[k];
            sb.push_back('{$sformatf("fwd_%0d", k), ev(fe[k], 1'b0, 1'b0, 1'b0, 5'd0, exp_cnt),
                           M_FWD | M_CTL});
            @(negedge clk);
            ent = sb.pop_front();
            checks++;
            if ((obs & ent.mask) !== (ent.exp & ent.mask)) begin
                errors++;
                $display("FAIL %s: got %h required %h", ent.name, obs & ent.mask, ent.exp & ent.mask);
            end else $display("txn %s obs=%h", ent.name, obs);
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        sb_t ent;
        // valid mask per step; step 1 drops id_src_valid[1]; step 2 has EX not a load
        logic [1:0] vld [3] = '{2'b10, 2'b01, 2'b10};
        logic       ld  [3] = '{1'b1, 1'b1, 1'b0};
        logic       sx;
        for (int k = 0; k < 3; k++) begin
            idex_mem_read = ld[k]; idex_reg_write = 1'b1; idex_rd = 5'd5;
            id_src_addr = {5'd5, 5'd0}; id_src_valid = vld[k];
            sx = (k == 0);
            sb.push_back('{$sformatf("load_use_%0d", k), ev(4'b0, sx, 1'b0, 1'b0, 5'd0, exp_cnt), M_CTL});
            @(negedge clk);
            ent = sb.pop_front();
            checks++;
            if ((obs & ent.mask) !== (ent.exp & ent.mask)) begin
                errors++;
                $display("FAIL %s: got %h required %h", ent.name, obs & ent.mask, ent.exp & ent.mask);
            end else $display("txn %s obs=%h", ent.name, obs);
            if (sx) exp_cnt = sat_inc(exp_cnt);
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_multicycle();
        sb_t ent;
        logic s;
        id_mc_start = 1'b1; id_mc_rd = 5'd7;
        sb.push_back('{"mc_start", ev(4'b0, 1'b0, 1'b0, 1'b0, 5'd0, exp_cnt), M_CTL});
        @(negedge clk);
        ent = sb.pop_front();
        checks++;
        if ((obs & ent.mask) !== (ent.exp & ent.mask)) begin
            errors++;
            $display("FAIL %s: got %h required %h", ent.name, obs & ent.mask, ent.exp & ent.mask);
        end else $display("txn %s obs=%h", ent.name, obs);
        next_cycle();
        // Cycle T onward: decode reads r7 while the op is in flight.
        id_mc_start = 1'b0; id_mc_rd = '0;
        id_src_addr = {5'd0, 5'd7}; id_src_valid = 2'b01;
        for (int k = 0; k < LAT + 1; k++) begin
            s = (k < LAT);
            sb.push_back('{$sformatf("mc_run_T+%0d", k),
                           ev(4'b0, s, s, (k == LAT - 1), s ? 5'd7 : 5'd0, exp_cnt), M_CTL});
            @(negedge clk);
            ent = sb.pop_front();
            checks++;
            if ((obs & ent.mask) !== (ent.exp & ent.mask)) begin
                errors++;
                $display("FAIL %s: got %h required %h", ent.name, obs & ent.mask, ent.exp & ent.mask);
            end else $display("txn %s obs=%h", ent.name, obs);
            if (s) exp_cnt = sat_inc(exp_cnt);
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        sb_t ent;
        logic b1, b2, s;
        id_mc_start = 1'b1; id_mc_rd = 5'd8;
        sb.push_back('{"b2b_first", ev(4'b0, 1'b0, 1'b0, 1'b0, 5'd0, exp_cnt), M_CTL});
        @(negedge clk);
        ent = sb.pop_front();
        checks++;
        if ((obs & ent.mask) !== (ent.exp & ent.mask)) begin
            errors++;
            $display("FAIL %s: got %h required %h", ent.name, obs & ent.mask, ent.exp & ent.mask);
        end else $display("txn %s obs=%h", ent.name, obs);
        next_cycle();
        id_mc_rd = 5'd9;
        // k = offset from T; second start held until accepted in cycle T+4
        for (int k = 0; k < 2 * LAT + 2; k++) begin
            b1 = (k < LAT);
            b2 = (k > LAT) && (k <= 2 * LAT);
            s  = b1;
            id_mc_start = (k <= LAT);
            sb.push_back('{$sformatf("b2b_T+%0d", k),
                           ev(4'b0, s, b1 | b2, (k == LAT - 1) || (k == 2 * LAT),
                              b1 ? 5'd8 : (b2 ? 5'd9 : 5'd0), exp_cnt), M_CTL});
            @(negedge clk);
            ent = sb.pop_front();
            checks++;
            if ((obs & ent.mask) !== (ent.exp & ent.mask)) begin
                errors++;
                $display("FAIL %s: got %h required %h", ent.name, obs & ent.mask, ent.exp & ent.mask);
            end else $display("txn %s obs=%h", ent.name, obs);
            if (s) exp_cnt = sat_inc(exp_cnt);
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_flush();
        sb_t ent;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_rd = 5'd5;
                id_src_addr = {5'd5, 5'd0}; id_src_valid = 2'b10;
                id_mc_start = 1'b1; id_mc_rd = 5'd6; id_flush = 1'b1;
            end else begin
                clear_inputs();
            end
            sb.push_back('{$sformatf("flush_%0d", k), ev(4'b0, 1'b0, 1'b0, 1'b0, 5'd0, exp_cnt), M_CTL});
            @(negedge clk);
            ent = sb.pop_front();
            checks++;
            if ((obs & ent.mask) !== (ent.exp & ent.mask)) begin
                errors++;
                $display("FAIL %s: got %h required %h", ent.name, obs & ent.mask, ent.exp & ent.mask);
            end else $display("txn %s obs=%h", ent.name, obs);
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_op();
        sb_t ent;
        logic [15:0] e;
        // k=0 start, k=1 (T) flush must not cancel, k=2 (T+1) reset, k>=3 no done pulse
        for (int k = 0; k < 6; k++) begin
            clear_inputs();
            reset = (k == 2);
            if (k == 0) begin id_mc_start = 1'b1; id_mc_rd = 5'd10; end
            if (k == 1) id_flush = 1'b1;
            if (k == 2) exp_cnt = '0;
            if (k == 1) e = ev(4'b0, 1'b0, 1'b1, 1'b0, 5'd10, exp_cnt);
            else        e = ev(4'b0, 1'b0, 1'b0, 1'b0, 5'd0, exp_cnt);
            sb.push_back('{$sformatf("reset_mid_%0d", k), e, M_CTL});
            @(negedge clk);
            ent = sb.pop_front();
            checks++;
            if ((obs & ent.mask) !== (ent.exp & ent.mask)) begin
                errors++;
                $display("FAIL %s: got %h required %h", ent.name, obs & ent.mask, ent.exp & ent.mask);
            end else $display("txn %s obs=%h", ent.name, obs);
            next_cycle();
        end
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        sb_t ent;
        logic s;
        for (int k = 0; k < (1 << CW) + 5 + 2; k++) begin
            s = (k < (1 << CW) + 5);
            idex_mem_read = s; idex_reg_write = 1'b1; idex_rd = 5'd12;
            id_src_addr = {5'd0, 5'd12}; id_src_valid = 2'b01;
            sb.push_back('{$sformatf("sat_%0d", k), ev(4'b0, s, 1'b0, 1'b0, 5'd0, exp_cnt), M_CTL});
            @(negedge clk);
            ent = sb.pop_front();
            checks++;
            if ((obs & ent.mask) !== (ent.exp & ent.mask)) begin
                errors++;
                $display("FAIL %s: got %h required %h", ent.name, obs & ent.mask, ent.exp & ent.mask);
            end else $display("txn %s obs=%h", ent.name, obs);
            if (s) exp_cnt = sat_inc(exp_cnt);
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_multicycle();
        test_back_to_back();
        test_flush();
        test_reset_mid_op();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
